// File: rtl/skid_pipe_reg.sv
// -----------------------------------------------------------------------------
// skid_pipe_reg
//
// Elastic one-stage pipeline register with a skid slot. The main register (M)
// drives out_data. The skid register (S) catches the word that arrives while
// the downstream stalls. Because of S, in_ready can come straight from a flop
// and carries no combinational path from out_ready. The block also has a
// synchronous flush and a saturating stall counter.
//
// Handshake: a word moves when valid and ready are both high on a rising edge.
// A producer must not drop valid or change data until that edge. Ready may
// change freely and never depends combinationally on valid.
//
// Ports
//   clock        rising-edge clock
//   reset        synchronous active-low reset
//   flush        synchronous flush, discards held words
//   in_valid     upstream word present
//   in_data      upstream word [WIDTH]
//   in_ready     block can accept a word (flop output)
//   out_valid    out_data holds a valid word
//   out_data     head word [WIDTH] (flop output)
//   out_ready    downstream accepts the word
//   occupancy    held words 0..2; this is also the FSM state
//   stall_count  saturating count of out_valid & !out_ready cycles [CNT_WIDTH]
// -----------------------------------------------------------------------------
module skid_pipe_reg #(
  parameter int                 WIDTH       = 32,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
  parameter int                 CNT_WIDTH   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  input  logic                 out_ready,
  output logic [1:0]           occupancy,
  output logic [CNT_WIDTH-1:0] stall_count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_main;
  logic [WIDTH-1:0]     w_main_nxt;
  logic [WIDTH-1:0]     r_skid;
  logic [WIDTH-1:0]     w_skid_nxt;
  logic                 r_in_ready;
  logic [CNT_WIDTH-1:0] r_stall;

  logic w_out_valid;
  logic w_in_fire;
  logic w_out_fire;
  logic w_stall_inc;

  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_in_fire   = in_valid & r_in_ready;
  assign w_out_fire  = w_out_valid & out_ready;
  // Once the counter is all ones it stops counting.
  assign w_stall_inc = w_out_valid & ~out_ready & ~(&r_stall);

  // Next-state and datapath selection.
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      // Words are discarded only by the state change. M and S keep stale
      // contents, and an input fire in this cycle is dropped.
      w_state_nxt = ST_EMPTY;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_main_nxt  = in_data;
            w_state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_main_nxt = in_data;
          end else if (w_in_fire) begin
            w_skid_nxt  = in_data;
            w_state_nxt = ST_FULL;
          end else if (w_out_fire) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the drain can happen.
          if (w_out_fire) begin
            w_main_nxt  = r_skid;
            w_state_nxt = ST_ONE;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= ST_EMPTY;
      r_main     <= RESET_VALUE;
      r_skid     <= RESET_VALUE;
      r_in_ready <= 1'b1;
      r_stall    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_main     <= w_main_nxt;
      r_skid     <= w_skid_nxt;
      // Register in_ready from the next state so that it is a pure flop.
      r_in_ready <= (w_state_nxt != ST_FULL);
      if (!flush && w_stall_inc) begin
        r_stall <= r_stall + 1'b1;
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = w_out_valid;
  assign out_data    = r_main;
  assign occupancy   = r_state;
  assign stall_count = r_stall;

endmodule

// File: tb/tb_skid_pipe_reg.sv
module tb_skid_pipe_reg;

  localparam int WIDTH     = 8;
  localparam int CNT_WIDTH = 3;

  logic                 clock;
  logic                 reset;
  logic                 flush;
  logic                 in_valid;
  logic [WIDTH-1:0]     in_data;
  logic                 in_ready;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic                 out_ready;
  logic [1:0]           occupancy;
  logic [CNT_WIDTH-1:0] stall_count;

  int n_checks = 0;
  int n_errors = 0;

  // Words expected on out_data, in order.
  logic [WIDTH-1:0] exp_q[$];

  skid_pipe_reg #(
    .WIDTH      (WIDTH),
    .RESET_VALUE(8'h00),
    .CNT_WIDTH  (CNT_WIDTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .occupancy  (occupancy),
    .stall_count(stall_count)
  );

  // Clock and reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Checking
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Compare out_data with the oldest expected word and retire it.
  task automatic check_head(input string tag);
    logic [WIDTH-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=<no word queued>", tag, out_data);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, {24'h0, out_data}, {24'h0, e});
    end
  endtask

  // Driver tasks: advance one edge, then settle 1 time unit before sampling.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic rdy);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
  endtask

  initial begin
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    out_ready = 1'b0;

    // Reset held for two edges while the input is offered.
    step();
    step();
    check_eq("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check_eq("rst_in_ready",  {31'h0, in_ready},  32'd1);
    check_eq("rst_occupancy", {30'h0, occupancy}, 32'd0);
    check_eq("rst_out_data",  {24'h0, out_data},  32'h0);
    check_eq("rst_stall",     {29'h0, stall_count}, 32'd0);

    // Streaming at full rate.
    reset = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, WIDTH'(i), 1'b1);
      exp_q.push_back(WIDTH'(i));
      step();
      check_head($sformatf("stream_data_%0d", i));
      check_eq($sformatf("stream_occ_%0d", i),   {30'h0, occupancy}, 32'd1);
      check_eq($sformatf("stream_rdy_%0d", i),   {31'h0, in_ready},  32'd1);
    end
    drive(1'b0, 8'h00, 1'b1);
    step();
    check_eq("stream_drain_occ",   {30'h0, occupancy}, 32'd0);
    check_eq("stream_drain_valid", {31'h0, out_valid}, 32'd0);
    check_eq("stream_stall",       {29'h0, stall_count}, 32'd0);

    // Backpressure and skid.
    drive(1'b1, 8'h10, 1'b0);
    exp_q.push_back(8'h10);
    step();
    check_eq("skid_occ_1",   {30'h0, occupancy}, 32'd1);
    check_eq("skid_rdy_1",   {31'h0, in_ready},  32'd1);
    drive(1'b1, 8'h20, 1'b0);
    exp_q.push_back(8'h20);
    step();
    check_eq("skid_occ_2",   {30'h0, occupancy}, 32'd2);
    check_eq("skid_rdy_2",   {31'h0, in_ready},  32'd0);
    check_eq("skid_data_2",  {24'h0, out_data},  32'h10);
    check_eq("skid_stall_2", {29'h0, stall_count}, 32'd1);
    drive(1'b1, 8'h30, 1'b0);
    step();
    check_eq("skid_blocked_occ",   {30'h0, occupancy}, 32'd2);
    check_eq("skid_blocked_data",  {24'h0, out_data},  32'h10);
    check_eq("skid_blocked_stall", {29'h0, stall_count}, 32'd2);
    check_head("skid_head_10");
    // 0x30 stays offered; it is refused this edge and accepted on the next.
    drive(1'b1, 8'h30, 1'b1);
    step();
    check_head("skid_head_20");
    check_eq("skid_drain_occ", {30'h0, occupancy}, 32'd1);
    check_eq("skid_drain_rdy", {31'h0, in_ready},  32'd1);
    exp_q.push_back(8'h30);
    step();
    check_head("skid_head_30");
    check_eq("skid_stall_hold", {29'h0, stall_count}, 32'd2);
    drive(1'b0, 8'h00, 1'b1);
    step();
    check_eq("skid_empty_occ", {30'h0, occupancy}, 32'd0);
    check_eq("skid_queue_left", exp_q.size(), 32'd0);

    // Stall counter saturation (counter starts at 2).
    drive(1'b1, 8'h42, 1'b0);
    step();
    check_eq("sat_start", {29'h0, stall_count}, 32'd2);
    drive(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) step();
    check_eq("sat_6", {29'h0, stall_count}, 32'd6);
    step();
    check_eq("sat_7", {29'h0, stall_count}, 32'd7);
    for (int i = 0; i < 5; i++) step();
    check_eq("sat_hold",      {29'h0, stall_count}, 32'd7);
    check_eq("sat_data_hold", {24'h0, out_data},    32'h42);
    check_eq("sat_occ",       {30'h0, occupancy},   32'd1);

    // Flush while FULL with 0x77 offered at the same edge.
    drive(1'b0, 8'h00, 1'b1);
    step();
    drive(1'b1, 8'h55, 1'b0);
    step();
    drive(1'b1, 8'h66, 1'b0);
    step();
    check_eq("flush_pre_occ",  {30'h0, occupancy}, 32'd2);
    check_eq("flush_pre_data", {24'h0, out_data},  32'h55);
    flush = 1'b1;
    drive(1'b1, 8'h77, 1'b0);
    step();
    flush = 1'b0;
    check_eq("flush_occ",   {30'h0, occupancy},   32'd0);
    check_eq("flush_valid", {31'h0, out_valid},   32'd0);
    check_eq("flush_rdy",   {31'h0, in_ready},    32'd1);
    check_eq("flush_stall", {29'h0, stall_count}, 32'd7);
    drive(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq($sformatf("flush_no77_%0d", i), {31'h0, out_valid}, 32'd0);
    end

    // Reset together with flush while FULL.
    drive(1'b1, 8'h88, 1'b0);
    step();
    drive(1'b1, 8'h99, 1'b0);
    step();
    check_eq("mrst_pre_occ", {30'h0, occupancy}, 32'd2);
    reset = 1'b0;
    flush = 1'b1;
    drive(1'b1, 8'hAB, 1'b0);
    step();
    check_eq("mrst_valid", {31'h0, out_valid},   32'd0);
    check_eq("mrst_rdy",   {31'h0, in_ready},    32'd1);
    check_eq("mrst_occ",   {30'h0, occupancy},   32'd0);
    check_eq("mrst_data",  {24'h0, out_data},    32'h0);
    check_eq("mrst_stall", {29'h0, stall_count}, 32'd0);

    // Normal operation resumes after reset; the counter restarts from zero.
    reset = 1'b1;
    flush = 1'b0;
    drive(1'b1, 8'hC3, 1'b0);
    step();
    check_eq("post_data",  {24'h0, out_data},    32'hC3);
    check_eq("post_stall", {29'h0, stall_count}, 32'd0);
    drive(1'b0, 8'h00, 1'b0);
    step();
    check_eq("post_stall_1", {29'h0, stall_count}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/skid_pipe_reg.md
# skid_pipe_reg

Parametrised elastic pipeline register, the next generation of the team's single-bit flip-flop with reset. It carries a WIDTH-bit word through one pipeline stage using a valid/ready handshake, and a second skid slot lets the upstream `in_ready` be driven purely from a flop. It also provides synchronous flush and a saturating backpressure counter. It sits between CPU/vector pipeline stages wherever a stage can stall.

## Interface
- `WIDTH`, default 32: data word width, ≥1.
- `RESET_VALUE`, default 0: value loaded into `out_data` and the skid register at reset.
- `CNT_WIDTH`, default 16: width of `stall_count`.

- `clock` input 1: rising-edge clock, the only clock.
- `reset` input 1: synchronous, active-low reset, sampled on the `clock` rising edge.
- `flush` input 1: synchronous flush; discards all held words.
- `in_valid` input 1: upstream word present.
- `in_data` input WIDTH: upstream word.
- `in_ready` output 1: block can accept a word; driven directly from a flop.
- `out_valid` output 1: `out_data` holds a valid word.
- `out_data` output WIDTH: head word; driven directly from a flop.
- `out_ready` input 1: downstream accepts the word.
- `occupancy` output 2: number of held words, 0..2.
- `stall_count` output CNT_WIDTH: count of cycles with `out_valid`=1 and `out_ready`=0; saturates.

## Operation
- Storage: main register (M, drives `out_data`) and skid register (S).
- State is encoded by `occupancy`: EMPTY=0, ONE=1, FULL=2.
- `out_valid` = (`occupancy` != 0).
- `in_ready` = (`occupancy` != 2), registered.
- Handshakes:
  - Input fire: `in_valid` & `in_ready`.
  - Output fire: `out_valid` & `out_ready`.
- Transitions at each rising edge, in priority order:
  1. `reset`=0: EMPTY; M ← RESET_VALUE; S ← RESET_VALUE; `stall_count` ← 0.
  2. `flush`=1: EMPTY; M and S keep their values; any input fire in this cycle is dropped; `stall_count` unchanged.
  3. EMPTY:
     - input fire → M ← `in_data`; go to ONE.
  4. ONE:
     - input and output fire → M ← `in_data`; stay ONE.
     - input fire only → S ← `in_data`; go to FULL.
     - output fire only → go to EMPTY; M keeps its value.
     - neither → hold.
  5. FULL (`in_ready`=0, so no input fire is possible):
     - output fire → M ← S; go to ONE.
     - otherwise hold.
- Ordering: words leave in the exact order they were accepted. No word is lost or duplicated except by `flush`/`reset`.
- `out_data` is stable while `out_valid`=1 and `out_ready`=0.
- `stall_count`:
  - Increments by 1 on each edge where `reset`=1, `flush`=0, `out_valid`=1 and `out_ready`=0.
  - Holds at 2^CNT_WIDTH−1 once reached.
- `in_valid` with `in_ready`=0 has no effect. Upstream must hold `in_data` until the fire.

## Timing
- Latency: a word accepted at edge N appears on `out_data` with `out_valid`=1 right after edge N, when the block was EMPTY, or one cycle behind the older word otherwise.
- Throughput: 1 word/cycle sustained when `out_ready`=1.
- `in_ready` falls one cycle after the fire that fills S. It rises right after the output fire that drains FULL.
- No combinational path from `out_ready` to `in_ready`, and none from `in_*` to `out_*`.
- Values immediately after a reset edge:
  - `out_valid`=0, `in_ready`=1, `occupancy`=0
  - `out_data`=RESET_VALUE, `stall_count`=0
- Reset in mid-operation (for example in FULL): everything returns to the reset values at that edge, and words in flight are discarded.
- Reset and flush asserted together: reset wins.
- `flush` in FULL: the next cycle shows `in_ready`=1 and `out_valid`=0.

## Test plan
- Reset: hold `reset`=0 for 2 edges with `in_valid`=1 and `in_data`=0xA5 → `out_valid`=0, `in_ready`=1, `occupancy`=0, `out_data`=0 (RESET_VALUE=0), `stall_count`=0.
- Streaming: release reset, keep `out_ready`=1, and send 0x1,0x2,0x3,0x4 on consecutive cycles → `out_data` shows 0x1..0x4 one cycle later each, `occupancy` stays 1, `in_ready` stays 1.
- Backpressure/skid: with `out_ready`=0, send 0x10 then 0x20 → `occupancy`=2, `in_ready`=0 on the 3rd cycle, `out_data`=0x10. Offer 0x30 while not ready → not accepted. Then raise `out_ready` → outputs 0x10, 0x20, then 0x30 once accepted.
- Stall counter: with WIDTH=8 and CNT_WIDTH=3, hold one word with `out_ready`=0 for 10 cycles → `stall_count` reaches 7 and holds there.
- Flush: in FULL (0x55, 0x66), assert `flush` for 1 cycle with `in_valid`=1 and `in_data`=0x77 → next cycle `occupancy`=0, `out_valid`=0, `in_ready`=1, and 0x77 is never output.
- Reset mid-operation: in FULL, drive `reset`=0 together with `flush`=1 for 1 edge → all outputs at their reset values, `out_data`=RESET_VALUE.
